// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: request kinds, RV32 opcodes,
// FSM states and a signed-range helper used by the immediate packer.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        K_R      = 3'd0,
        K_IARITH = 3'd1,
        K_LOAD   = 3'd2,
        K_S      = 3'd3,
        K_B      = 3'd4,
        K_JAL    = 3'd5,
        K_LUI    = 3'd6,
        K_ILL    = 3'd7
    } kind_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // True when v is representable as a signed value whose sign bit is bit msb.
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic [31:0] sh;
        sh = 32'($signed(v) >>> msb);
        return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: builds the 32-bit RV32 instruction word for a request
// and flags whether the request is encodable.
module instr_encoder_imm_pack
    import instr_encoder_pkg::*;
(
    input  kind_e       kind_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Field placement per instruction class plus immediate range checks.
    always_comb begin
        word_o  = 32'h0000_0000;
        legal_o = 1'b0;
        case (kind_i)
            K_R: begin
                word_o  = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
                legal_o = 1'b1;
            end
            K_IARITH: begin
                // Shift-right forms carry funct7b5 in place of the upper immediate bits.
                if (funct3_i == 3'd5) begin
                    word_o = {1'b0, funct7b5_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_I};
                end else begin
                    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
                end
                legal_o = fits_signed(imm_i, 11);
            end
            K_LOAD: begin
                word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                legal_o = fits_signed(imm_i, 11);
            end
            K_S: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_S};
                legal_o = fits_signed(imm_i, 11);
            end
            K_B: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OP_B};
                legal_o = fits_signed(imm_i, 12) && !imm_i[0];
            end
            K_JAL: begin
                word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                legal_o = fits_signed(imm_i, 20) && !imm_i[0];
            end
            K_LUI: begin
                word_o  = {imm_i[31:12], rd_i, OP_LUI};
                legal_o = (imm_i[11:0] == 12'h000);
            end
            default: begin
                word_o  = 32'h0000_0000;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction loader: accepts encode requests during a session and writes the
// packed words to consecutive instruction-memory addresses starting at 0.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          finish,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    kind,
    input  logic [2:0]    funct3,
    input  logic          funct7b5,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_e        state_q;
    logic [AW:0]   count_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   word_s;
    logic          legal_s;

    instr_encoder_imm_pack u_imm_pack (
        .kind_i     (kind_e'(kind)),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .imm_i      (imm),
        .word_o     (word_s),
        .legal_o    (legal_s)
    );

    assign req_ready = (state_q == S_LOAD) && (count_q < DEPTH_C) && !start && !finish;

    // Session FSM with the memory write port and counters registered alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (start) begin
                        count_q <= '0;
                    end else if (finish) begin
                        state_q <= S_DONE;
                    end else if (req_valid && req_ready) begin
                        if (legal_s) begin
                            we_q    <= 1'b1;
                            addr_q  <= count_q[AW-1:0];
                            wdata_q <= word_s;
                            count_q <= count_q + (AW+1)'(1);
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4): directed scenarios followed by
// randomized sessions checked against an arithmetic reference encoder.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

    logic          clk = 1'b0;
    logic          reset, start, finish, req_valid, req_ready;
    logic [2:0]    kind, funct3;
    logic          funct7b5;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          done, err;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .kind(kind),
        .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int wr_cnt    = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    int m_mode = M_IDLE;
    int m_cnt  = 0;
    bit m_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference encoder built from field arithmetic and integer range tests.
    function automatic logic [31:0] ref_encode(input logic [31:0] k, f3, f7, rdv, r1, r2,
                                               input logic [31:0] iv, output bit legal);
        longint s;
        logic [31:0] w;
        s = longint'($signed(iv));
        w = 32'h0;
        legal = 1'b0;
        case (k)
            0: begin
                w = 32'h33 | (rdv << 7) | (f3 << 12) | (r1 << 15) | (r2 << 20) | (f7 << 30);
                legal = 1'b1;
            end
            1, 2: begin
                w = ((k == 1) ? 32'h13 : 32'h03) | (rdv << 7) | (f3 << 12) | (r1 << 15)
                    | ((iv & 32'hFFF) << 20);
                if (k == 1 && f3 == 5) w = (w & ~(32'h7F << 25)) | (f7 << 30);
                legal = (s >= -2048) && (s <= 2047);
            end
            3: begin
                w = 32'h23 | ((iv & 32'h1F) << 7) | (f3 << 12) | (r1 << 15) | (r2 << 20)
                    | (((iv >> 5) & 32'h7F) << 25);
                legal = (s >= -2048) && (s <= 2047);
            end
            4: begin
                w = 32'h63 | (((iv >> 11) & 1) << 7) | (((iv >> 1) & 32'hF) << 8) | (f3 << 12)
                    | (r1 << 15) | (r2 << 20) | (((iv >> 5) & 32'h3F) << 25)
                    | (((iv >> 12) & 1) << 31);
                legal = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            end
            5: begin
                w = 32'h6F | (rdv << 7) | (((iv >> 12) & 32'hFF) << 12) | (((iv >> 11) & 1) << 20)
                    | (((iv >> 1) & 32'h3FF) << 21) | (((iv >> 20) & 1) << 31);
                legal = (s >= -(64'sd1 << 20)) && (s <= (64'sd1 << 20) - 2) && (s % 2 == 0);
            end
            6: begin
                w = 32'h37 | (rdv << 7) | (iv & 32'hFFFF_F000);
                legal = ((iv & 32'hFFF) == 0);
            end
            default: legal = 1'b0;
        endcase
        return w;
    endfunction

    // Drive one cycle, advance the session model, and check outputs.
    task automatic step(input bit st, fi, va, input logic [2:0] k, f3, input bit f7,
                        input logic [4:0] rdv, r1, r2, input logic [31:0] iv,
                        input bit use_exp, input logic [31:0] exp_w);
        bit ready, legal;
        logic [31:0] w;
        reset = 1'b0; start = st; finish = fi; req_valid = va;
        kind = k; funct3 = f3; funct7b5 = f7; rd = rdv; rs1 = r1; rs2 = r2; imm = iv;
        #1;
        ready = (m_mode == M_LOAD) && (m_cnt < DEPTH) && !st && !fi;
        chk("req_ready", {31'b0, req_ready}, {31'b0, ready});
        case (m_mode)
            M_LOAD: begin
                if (st) m_cnt = 0;
                else if (fi) m_mode = M_DONE;
                else if (va && ready) begin
                    w = ref_encode(32'(k), 32'(f3), 32'(f7), 32'(rdv), 32'(r1), 32'(r2), iv, legal);
                    if (legal) begin
                        exp_addr_q.push_back(32'(m_cnt));
                        exp_data_q.push_back(use_exp ? exp_w : w);
                        m_cnt++;
                    end else begin
                        m_err = 1'b1;
                        m_mode = M_ERR;
                    end
                end
            end
            default: if (st) begin m_mode = M_LOAD; m_cnt = 0; m_err = 1'b0; end
        endcase
        @(posedge clk); #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("err", {31'b0, err}, {31'b0, m_err});
        chk("done", {31'b0, done}, {31'b0, (m_mode == M_DONE)});
    endtask

    task automatic idle();
        step(0, 0, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
    endtask

    task automatic req(input logic [2:0] k, f3, input bit f7, input logic [4:0] rdv, r1, r2,
                       input logic [31:0] iv, input logic [31:0] exp_w);
        step(0, 0, 1, k, f3, f7, rdv, r1, r2, iv, 1, exp_w);
    endtask

    // Reset with a request presented in the same cycle; no write may follow.
    task automatic do_reset();
        reset = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b1;
        kind = 3'd0; funct3 = 3'd0; funct7b5 = 1'b0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd0;
        @(posedge clk); #1;
        m_mode = M_IDLE; m_cnt = 0; m_err = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0; req_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm(input int k);
        int r, v;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) begin
            case ($urandom_range(0, 7))
                0: v = 2047;  1: v = 2048;  2: v = -2048; 3: v = -2049;
                4: v = 4094;  5: v = -4096; 6: v = 4096;  default: v = (1 << 20) - 2;
            endcase
            return 32'(v);
        end
        case (k)
            1, 2, 3: v = int'($urandom_range(0, 4095)) - 2048;
            4: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            5: v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
            6: return $urandom & 32'hFFFF_F000;
            default: v = int'($urandom);
        endcase
        return 32'(v);
    endfunction

    // Monitor: every memory write must match the oldest expected entry.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_addr_q.size() == 0) begin
                chk("spurious_we", {31'b0, mem_we}, 32'd0);
            end else begin
                chk("wr_addr", 32'(mem_addr), exp_addr_q.pop_front());
                chk("wr_data", mem_wdata, exp_data_q.pop_front());
            end
            wr_cnt++;
        end
    end

    initial begin
        int w0;
        logic [2:0] k;
        do_reset();
        idle();

        step(1, 0, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        req(3'd0, 3'd0, 0, 5'd3, 5'd1, 5'd2, 32'd0,       32'h002081B3);
        req(3'd1, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5,       32'h00500093);
        req(3'd3, 3'd2, 0, 5'd0, 5'd1, 5'd2, 32'd8,       32'h0020A423);
        req(3'd4, 3'd0, 0, 5'd0, 5'd0, 5'd0, -32'sd4,     32'hFE000EE3);
        step(0, 1, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        step(1, 0, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        req(3'd5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd8,       32'h008000EF);
        req(3'd4, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd3,       32'h0);
        idle();
        step(1, 0, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);

        w0 = wr_cnt;
        for (int i = 0; i < 6; i++)
            step(0, 0, 1, 3'd0, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 32'd0, 0, 32'd0);
        idle();
        chk("full_writes", 32'(wr_cnt - w0), 32'd4);
        step(0, 1, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);

        step(1, 0, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        step(0, 1, 1, 3'd0, 3'd0, 0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'd0);
        idle();
        step(1, 0, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        req(3'd6, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7);
        do_reset();
        idle();

        for (int s = 0; s < 40; s++) begin
            step(1, 0, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
            for (int c = 0; c < 8; c++) begin
                k = 3'($urandom_range(0, 7));
                step($urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0, k, 3'($urandom), 1'($urandom),
                     5'($urandom), 5'($urandom), 5'($urandom), rand_imm(int'(k)), 0, 32'd0);
            end
            step(0, 1, 0, 3'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        end
        idle();
        idle();
        chk("sb_empty", 32'(exp_addr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
